seq_lfsr_player: RTL and testbench

Parametrised successor to the fixed 16-entry color-sequence ROM of the Genius game.
- Generates the game's one-hot color sequence from a 16-bit Galois LFSR seeded at start, so any sequence length up to MAXLEN is reproducible from one seed.
- Plays the sequence back itself, either timed (HOLD/GAP cycles per symbol) or stepped (one symbol per `proximo` pulse).
- Sits between the game controller (seed, level, start) and the LED/compare logic (`saida`, `valido`).

---
 rtl/seq_pkg.sv | 36 +++
 rtl/lfsr16.sv | 34 +++
 rtl/seq_lfsr_player.sv | 206 ++++++++++++++++++++
 tb/tb_seq_lfsr_player.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the LFSR-driven color sequence player.
// Provides the playback state encoding, the LFSR constants and small helpers
// for stepping the LFSR and decoding a one-hot color.
package seq_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StShow = 2'd1,
    StGap  = 2'd2,
    StDone = 2'd3
  } state_e;

  localparam logic [15:0] LFSR_MASK  = 16'hB400;
  localparam logic [15:0] LFSR_SEED0 = 16'h0001;

  // One-hot color from a color index.
  function automatic logic [15:0] onehot(input logic [3:0] idx);
    return 16'h0001 << idx;
  endfunction

  // Galois right-shift step.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : 16'h0000);
  endfunction

  // An all-zero state would lock the LFSR, so it is replaced on load.
  function automatic logic [15:0] seed_fix(input logic [15:0] s);
    return (s == 16'h0000) ? LFSR_SEED0 : s;
  endfunction

  // Color index taken from the low LFSR bits; m is NCORES-1.
  function automatic logic [3:0] sym_idx(input logic [15:0] s, input logic [3:0] m);
    return s[3:0] & m;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR holding the sequence state.
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous active-high reset, state returns to LFSR_SEED0
//   load   - load seed (zero seed replaced by LFSR_SEED0); has priority over step
//   seed   - seed value
//   step   - advance the LFSR one step
//   estado - current LFSR state
module lfsr16
  import seq_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] estado
);

  logic [15:0] estado_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= LFSR_SEED0;
    end else if (load) begin
      estado_q <= seed_fix(seed);
    end else if (step) begin
      estado_q <= lfsr_next(estado_q);
    end
  end

  assign estado = estado_q;

endmodule

// File: rtl/seq_lfsr_player.sv
// Color sequence player for the Genius game: generates the one-hot color
// sequence from a seeded 16-bit LFSR and plays it back, timed or stepped.
// Ports:
//   clock, reset   - rising-edge clock, synchronous active-high reset
//   seed           - LFSR seed, latched on accepted start
//   nivel          - sequence length (clamped to MAXLEN), latched on start
//   modo           - 0 timed playback, 1 step mode; latched on start
//   start          - begin playback (only accepted in idle)
//   proximo        - step mode: advance to next symbol
//   parar          - abort playback
//   saida          - one-hot current color, 0 when dark
//   valido         - saida holds a sequence symbol
//   indice         - 0-based index of current symbol
//   ocupado        - playback in progress
//   fim            - one-cycle pulse when the sequence completes
module seq_lfsr_player
  import seq_pkg::*;
#(
  parameter int unsigned NCORES = 4,
  parameter int unsigned MAXLEN = 16,
  parameter int unsigned HOLD   = 8,
  parameter int unsigned GAP    = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [15:0]                   seed,
  input  logic [$clog2(MAXLEN+1)-1:0]   nivel,
  input  logic                          modo,
  input  logic                          start,
  input  logic                          proximo,
  input  logic                          parar,
  output logic [NCORES-1:0]             saida,
  output logic                          valido,
  output logic [$clog2(MAXLEN)-1:0]     indice,
  output logic                          ocupado,
  output logic                          fim
);

  localparam int unsigned LW   = $clog2(MAXLEN + 1);
  localparam int unsigned IW   = $clog2(MAXLEN);
  localparam int unsigned TMAX = (HOLD > GAP) ? HOLD : GAP;
  localparam int unsigned CW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  state_e            state_q, state_d;
  logic [LW-1:0]     nivel_q, nivel_d, nivel_cl;
  logic              modo_q, modo_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              lfsr_load, lfsr_step;
  logic [15:0]       lfsr_q, lfsr_nxt;
  logic              is_last;

  logic [NCORES-1:0] saida_q, saida_d;
  logic              valido_q, valido_d;
  logic [IW-1:0]     indice_q, indice_d;
  logic              ocupado_q, ocupado_d;
  logic              fim_q, fim_d;

  lfsr16 u_lfsr (
    .clock  (clock),
    .reset  (reset),
    .load   (lfsr_load),
    .seed   (seed),
    .step   (lfsr_step),
    .estado (lfsr_q)
  );

  assign nivel_cl = (nivel > LW'(MAXLEN)) ? LW'(MAXLEN) : nivel;
  assign is_last  = ((LW'(idx_q) + LW'(1)) == nivel_q);

  always_comb begin
    state_d   = state_q;
    nivel_d   = nivel_q;
    modo_d    = modo_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && !parar) begin
          lfsr_load = 1'b1;
          nivel_d   = nivel_cl;
          modo_d    = modo;
          idx_d     = '0;
          cnt_d     = '0;
          state_d   = (nivel_cl == '0) ? StDone : StShow;
        end
      end
      StShow: begin
        if (modo_q) begin
          if (proximo) begin
            lfsr_step = 1'b1;
            if (is_last) begin
              state_d = StDone;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end
        end else if (cnt_q == CW'(HOLD - 1)) begin
          lfsr_step = 1'b1;
          cnt_d     = '0;
          if (GAP != 0) begin
            state_d = StGap;
          end else if (is_last) begin
            state_d = StDone;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StGap: begin
        if (cnt_q == CW'(GAP - 1)) begin
          cnt_d = '0;
          if (is_last) begin
            state_d = StDone;
          end else begin
            state_d = StShow;
            idx_d   = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort overrides any advance or step decided above.
    if (parar && (state_q != StIdle)) begin
      state_d   = StIdle;
      idx_d     = '0;
      cnt_d     = '0;
      lfsr_step = 1'b0;
    end
  end

  // Mirror of the LFSR update so the registered outputs track the new symbol.
  assign lfsr_nxt = lfsr_load ? seed_fix(seed) :
                    lfsr_step ? lfsr_next(lfsr_q) : lfsr_q;

  always_comb begin
    saida_d   = '0;
    valido_d  = 1'b0;
    indice_d  = '0;
    ocupado_d = 1'b0;
    fim_d     = 1'b0;
    unique case (state_d)
      StShow: begin
        saida_d   = NCORES'(onehot(sym_idx(lfsr_nxt, 4'(NCORES - 1))));
        valido_d  = 1'b1;
        indice_d  = idx_d;
        ocupado_d = 1'b1;
      end
      StGap: begin
        indice_d  = idx_d;
        ocupado_d = 1'b1;
      end
      StDone: begin
        fim_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      nivel_q   <= '0;
      modo_q    <= 1'b0;
      idx_q     <= '0;
      cnt_q     <= '0;
      saida_q   <= '0;
      valido_q  <= 1'b0;
      indice_q  <= '0;
      ocupado_q <= 1'b0;
      fim_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      nivel_q   <= nivel_d;
      modo_q    <= modo_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      saida_q   <= saida_d;
      valido_q  <= valido_d;
      indice_q  <= indice_d;
      ocupado_q <= ocupado_d;
      fim_q     <= fim_d;
    end
  end

  assign saida   = saida_q;
  assign valido  = valido_q;
  assign indice  = indice_q;
  assign ocupado = ocupado_q;
  assign fim     = fim_q;

endmodule

// File: tb/tb_seq_lfsr_player.sv
// Self-checking bench for seq_lfsr_player. Instance a: HOLD=2, GAP=1.
// Instance b: HOLD=1, GAP=0. Both NCORES=4, MAXLEN=16.
module tb_seq_lfsr_player;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, start_a, start_b, proximo, parar, modo;
  logic [15:0] seed;
  logic [4:0]  nivel;

  logic [3:0] saida_a, saida_b, indice_a, indice_b;
  logic       valido_a, valido_b, ocupado_a, ocupado_b, fim_a, fim_b;

  seq_lfsr_player #(.NCORES(4), .MAXLEN(16), .HOLD(2), .GAP(1)) dut_a (
    .clock   (clk),
    .reset   (rst_a),
    .seed    (seed),
    .nivel   (nivel),
    .modo    (modo),
    .start   (start_a),
    .proximo (proximo),
    .parar   (parar),
    .saida   (saida_a),
    .valido  (valido_a),
    .indice  (indice_a),
    .ocupado (ocupado_a),
    .fim     (fim_a)
  );

  seq_lfsr_player #(.NCORES(4), .MAXLEN(16), .HOLD(1), .GAP(0)) dut_b (
    .clock   (clk),
    .reset   (rst_b),
    .seed    (seed),
    .nivel   (nivel),
    .modo    (modo),
    .start   (start_b),
    .proximo (1'b0),
    .parar   (1'b0),
    .saida   (saida_b),
    .valido  (valido_b),
    .indice  (indice_b),
    .ocupado (ocupado_b),
    .fim     (fim_b)
  );

  typedef struct {
    logic [3:0] saida;
    logic       valido;
    logic [3:0] indice;
    logic       chk_idx;
    logic       ocupado;
    logic       fim;
  } vec_t;

  vec_t tv[11];
  int   n_pass = 0;
  int   n_chk  = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a_idle(input string tag);
    check({tag, " saida"},   16'(saida_a),   16'h0);
    check({tag, " valido"},  16'(valido_a),  16'h0);
    check({tag, " indice"},  16'(indice_a),  16'h0);
    check({tag, " ocupado"}, 16'(ocupado_a), 16'h0);
    check({tag, " fim"},     16'(fim_a),     16'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int   nsym;
    int   last_idx;
    logic got_fim;
    logic saw;

    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    proximo = 1'b0; parar = 1'b0; modo = 1'b0; seed = 16'h0; nivel = 5'd0;

    // Test 1 expected response, cycles 1..11
    tv[0]  = '{4'b1000, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0};
    tv[1]  = '{4'b1000, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0};
    tv[2]  = '{4'b0000, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0};
    tv[3]  = '{4'b1000, 1'b1, 4'd1, 1'b1, 1'b1, 1'b0};
    tv[4]  = '{4'b1000, 1'b1, 4'd1, 1'b1, 1'b1, 1'b0};
    tv[5]  = '{4'b0000, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0};
    tv[6]  = '{4'b0010, 1'b1, 4'd2, 1'b1, 1'b1, 1'b0};
    tv[7]  = '{4'b0010, 1'b1, 4'd2, 1'b1, 1'b1, 1'b0};
    tv[8]  = '{4'b0000, 1'b0, 4'd2, 1'b1, 1'b1, 1'b0};
    tv[9]  = '{4'b0000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1};
    tv[10] = '{4'b0000, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0};

    tick(); tick();
    check_a_idle("reset a");
    check("reset b saida", 16'(saida_b), 16'h0);
    check("reset b ocupado", 16'(ocupado_b), 16'h0);
    rst_a = 1'b0; rst_b = 1'b0;
    tick();

    // Test 1: timed decode
    seed = 16'h0007; nivel = 5'd3; modo = 1'b0; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 11; i++) begin
      check($sformatf("t1 saida c%0d", i + 1),   16'(saida_a),   16'(tv[i].saida));
      check($sformatf("t1 valido c%0d", i + 1),  16'(valido_a),  16'(tv[i].valido));
      if (tv[i].chk_idx)
        check($sformatf("t1 indice c%0d", i + 1), 16'(indice_a), 16'(tv[i].indice));
      check($sformatf("t1 ocupado c%0d", i + 1), 16'(ocupado_a), 16'(tv[i].ocupado));
      check($sformatf("t1 fim c%0d", i + 1),     16'(fim_a),     16'(tv[i].fim));
      tick();
    end

    // Test 2: zero seed equals seed 1
    for (int k = 0; k < 2; k++) begin
      seed = (k == 0) ? 16'h0000 : 16'h0001; nivel = 5'd2; start_b = 1'b1;
      tick();
      start_b = 1'b0;
      check($sformatf("t2.%0d sym0", k), 16'(saida_b), 16'h0002);
      check($sformatf("t2.%0d idx0", k), 16'(indice_b), 16'h0);
      tick();
      check($sformatf("t2.%0d sym1", k), 16'(saida_b), 16'h0001);
      check($sformatf("t2.%0d idx1", k), 16'(indice_b), 16'h1);
      tick();
      check($sformatf("t2.%0d fim", k), 16'(fim_b), 16'h1);
      check($sformatf("t2.%0d ocupado", k), 16'(ocupado_b), 16'h0);
      tick();
    end

    // Test 3: step mode
    proximo = 1'b1;
    tick();
    proximo = 1'b0;
    check("t3 early proximo ocupado", 16'(ocupado_a), 16'h0);
    check("t3 early proximo saida", 16'(saida_a), 16'h0);
    seed = 16'h0007; nivel = 5'd3; modo = 1'b1; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t3 hold sym0 c%0d", k), 16'(saida_a), 16'h8);
      check($sformatf("t3 hold idx0 c%0d", k), 16'(indice_a), 16'h0);
      if (k < 4) tick();
    end
    proximo = 1'b1; tick(); proximo = 1'b0;
    check("t3 sym1", 16'(saida_a), 16'h8);
    check("t3 idx1", 16'(indice_a), 16'h1);
    tick();
    check("t3 sym1 held", 16'(saida_a), 16'h8);
    proximo = 1'b1; tick(); proximo = 1'b0;
    check("t3 sym2", 16'(saida_a), 16'h2);
    check("t3 idx2", 16'(indice_a), 16'h2);
    proximo = 1'b1; tick(); proximo = 1'b0;
    check("t3 fim", 16'(fim_a), 16'h1);
    check("t3 fim ocupado", 16'(ocupado_a), 16'h0);
    check("t3 fim saida", 16'(saida_a), 16'h0);
    tick();
    check("t3 fim pulse", 16'(fim_a), 16'h0);
    modo = 1'b0;

    // Test 4a: nivel 0
    nivel = 5'd0; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("t4 nivel0 fim", 16'(fim_a), 16'h1);
    check("t4 nivel0 ocupado", 16'(ocupado_a), 16'h0);
    check("t4 nivel0 valido", 16'(valido_a), 16'h0);
    tick();
    check("t4 nivel0 fim end", 16'(fim_a), 16'h0);
    check("t4 nivel0 ocupado end", 16'(ocupado_a), 16'h0);

    // Test 4b: nivel above MAXLEN clamps
    seed = 16'h0007; nivel = 5'd21; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    nsym = 0; last_idx = -1; got_fim = 1'b0;
    for (int c = 0; c < 60 && !got_fim; c++) begin
      if (fim_b) got_fim = 1'b1;
      else begin
        if (valido_b) begin
          nsym++;
          last_idx = int'(indice_b);
        end
        tick();
      end
    end
    check("t4 clamp fim seen", 16'(got_fim), 16'h1);
    check("t4 clamp count", 16'(nsym), 16'd16);
    check("t4 clamp last idx", 16'(last_idx), 16'd15);
    tick();

    // Test 5: ignored start, abort
    seed = 16'h0007; nivel = 5'd3; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    start_a = 1'b1; seed = 16'h0001;
    tick();
    start_a = 1'b0; seed = 16'h0007;
    check("t5 busy start gap valido", 16'(valido_a), 16'h0);
    check("t5 busy start gap ocupado", 16'(ocupado_a), 16'h1);
    tick();
    check("t5 busy start sym1", 16'(saida_a), 16'h8);
    check("t5 busy start idx1", 16'(indice_a), 16'h1);
    parar = 1'b1;
    tick();
    parar = 1'b0;
    check_a_idle("t5 abort");
    saw = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (fim_a) saw = 1'b1;
      tick();
    end
    check("t5 abort no fim", 16'(saw), 16'h0);

    // Reset during GAP
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick(); tick();
    check("t5 in gap valido", 16'(valido_a), 16'h0);
    check("t5 in gap ocupado", 16'(ocupado_a), 16'h1);
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    check_a_idle("t5 reset");
    tick();

    // Test 6: back-to-back start
    seed = 16'h0007; nivel = 5'd1; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("t6 sym0", 16'(saida_a), 16'h8);
    tick(); tick(); tick();
    check("t6 fim", 16'(fim_a), 16'h1);
    start_a = 1'b1; seed = 16'h0002;
    tick();
    check("t6 start in fim ignored valido", 16'(valido_a), 16'h0);
    check("t6 start in fim ignored ocupado", 16'(ocupado_a), 16'h0);
    seed = 16'h0001;
    tick();
    start_a = 1'b0;
    check("t6 new seed sym", 16'(saida_a), 16'h2);
    check("t6 new seed valido", 16'(valido_a), 16'h1);
    check("t6 new seed idx", 16'(indice_a), 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
